pipe_alu: RTL
=============

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the operation request is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept a request.
REQ-006 SHALL have port op, input, 4, meaning opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL; 11-15 are illegal.
REQ-007 SHALL have ports a and b, input, WIDTH, meaning operands.
REQ-008 SHALL have port out_valid, output, 1, meaning result and flags are valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 SHALL have port result, output, WIDTH, meaning the registered result.
REQ-011 SHALL have ports zero, neg, carry, ovf and err, output, 1 each, meaning registered status flags.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 A request SHALL be accepted when in_valid and in_ready are both 1; op, a and b SHALL be captured on that edge.
REQ-014 Non-MUL ops SHALL go IDLE->DONE with result and flags registered, so out_valid rises exactly 1 cycle after acceptance.
REQ-015 MUL SHALL go IDLE->BUSY and run an iterative shift-add over a 2*WIDTH accumulator for WIDTH cycles, then go BUSY->DONE, so out_valid rises exactly WIDTH+1 cycles after acceptance.
REQ-016 In DONE, out_valid SHALL be 1 and result/flags SHALL be held stable until out_ready is 1, then the FSM SHALL go DONE->IDLE (no same-cycle re-accept).
REQ-017 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-018 ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-019 For ADD/SUB, carry SHALL be the carry-out (ADD) or borrow, i.e. a<b unsigned (SUB).
REQ-020 For ADD/SUB, ovf SHALL be signed two's-complement overflow.
REQ-021 Shifts SHALL use only b[log2(WIDTH)-1:0] as the amount; SRA SHALL sign-fill.
REQ-022 SLT/SLTU SHALL produce 1 or 0 in result bit 0, with upper bits 0.
REQ-023 MUL SHALL produce the low WIDTH bits of the unsigned product, with ovf=1 if and only if the upper WIDTH bits are nonzero.
REQ-024 zero SHALL equal (result==0) and neg SHALL equal result[WIDTH-1] for all ops; carry and ovf SHALL be 0 except as stated in REQ-019, REQ-020 and REQ-023.
REQ-025 Illegal opcodes SHALL complete with 1-cycle latency, result=0, err=1, zero=1 and all other flags 0; err SHALL be 0 for legal ops.

Reset
REQ-026 On rst_n low, the FSM SHALL enter IDLE immediately; out_valid, result, zero, neg, carry, ovf, err, the MUL counter and the accumulator SHALL all be 0; in_ready SHALL be 1.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation with no result delivered; the first request after rst_n release SHALL be accepted normally.

Configuration
REQ-028 Macro PIPE_ALU_MUL_EN defined SHALL include the BUSY state, counter, accumulator and MUL as specified above.
REQ-029 Macro PIPE_ALU_MUL_EN undefined SHALL remove the multiplier logic, never enter BUSY, and treat opcode 10 as illegal per REQ-025.

Verification (WIDTH=32)
REQ-030 ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, ovf=1, neg=1, carry=0; out_valid asserted 1 cycle after acceptance.
REQ-031 SUB a=3, b=5 -> result 0xFFFFFFFE, carry=1, neg=1, ovf=0; then SLT a=0xFFFFFFFF, b=1 -> result 1; SLTU with the same operands -> result 0.
REQ-032 SRA a=0x80000000, b=0x24 -> result 0xF8000000 (shift amount 4); SLL a=1, b=31 -> result 0x80000000.
REQ-033 MUL a=0x10000, b=0x10000 with the macro defined -> result 0, zero=1, ovf=1, out_valid exactly 33 cycles after acceptance; with the macro undefined -> err=1 after 1 cycle.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> result and flags unchanged, in_ready=0 throughout; out_ready=1 -> IDLE on the next cycle and in_ready=1.
REQ-035 Assert rst_n low in the 10th BUSY cycle of a MUL -> all outputs 0 and in_ready=1 immediately; ADD 2+2 after release -> result 4.

Source files
------------

// File: rtl/pipe_alu.sv
// pipe_alu: single-issue ALU with a valid/ready request side and a held result side.
//
// Optional feature: define PIPE_ALU_MUL_EN to build the iterative shift-add multiplier
// (opcode 10). Without it, opcode 10 completes as an illegal opcode.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  request handshake; in_ready is high only while idle
//   op, a, b            opcode and operands, captured on acceptance
//   out_valid, out_ready  result handshake; result and flags hold until out_ready
//   result              registered result
//   zero, neg, carry, ovf, err  registered status flags
module pipe_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned ShW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic             accept;
  logic             load_alu;
  logic             is_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf, alu_err;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [ShW-1:0]   shamt;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid & in_ready;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = a - b;
  assign shamt    = b[ShW-1:0];

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    is_mul    = 1'b0;
    case (op)
      4'd0: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        alu_res   = sub_diff;
        alu_carry = (a < b);
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: alu_res = a & b;
      4'd3: alu_res = a | b;
      4'd4: alu_res = a ^ b;
      4'd5: alu_res = a << shamt;
      4'd6: alu_res = a >> shamt;
      4'd7: alu_res = $unsigned($signed(a) >>> shamt);
      4'd8: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef PIPE_ALU_MUL_EN
      4'd10: is_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef PIPE_ALU_MUL_EN
  // Accumulator holds {partial product high half, remaining multiplier bits}; each step
  // conditionally adds the multiplicand to the high half and shifts the whole thing right.
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [ShW-1:0]     cnt_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic               mul_last;
  logic               load_mul;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_last = (cnt_q == ShW'(WIDTH - 1));
  assign load_mul = (state_q == StBusy) && mul_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (accept && is_mul) begin
      mcand_q <= a;
      acc_q   <= {{WIDTH{1'b0}}, b};
      cnt_q   <= '0;
    end else if (state_q == StBusy) begin
      acc_q   <= acc_step;
      cnt_q   <= cnt_q + 1'b1;
    end
  end
`endif

  assign load_alu = accept && !is_mul;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = is_mul ? StBusy : StDone;
      end
      StBusy: begin
`ifdef PIPE_ALU_MUL_EN
        if (mul_last) state_d = StDone;
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else if (load_alu) begin
      result <= alu_res;
      zero   <= (alu_res == '0);
      neg    <= alu_res[WIDTH-1];
      carry  <= alu_carry;
      ovf    <= alu_ovf;
      err    <= alu_err;
`ifdef PIPE_ALU_MUL_EN
    end else if (load_mul) begin
      result <= acc_step[WIDTH-1:0];
      zero   <= (acc_step[WIDTH-1:0] == '0);
      neg    <= acc_step[WIDTH-1];
      carry  <= 1'b0;
      ovf    <= |acc_step[2*WIDTH-1:WIDTH];
      err    <= 1'b0;
`endif
    end
  end

endmodule
